// File: rtl/cnt_target_arb_if.sv
// Request/target bus between requesters, the shared counter and cnt_target_arb.
// Combinational bundle, no storage of its own.
// master = requester/counter side, slave = the arbiter.
interface cnt_target_arb_if #(parameter int W = 4);
  logic [1:0]   req;
  logic [W-1:0] tgt0;
  logic [W-1:0] tgt1;
  logic [W-1:0] cnt_q;
  logic         cnt_step;
  logic         cnt_down;
  logic [1:0]   grant;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output req, tgt0, tgt1, cnt_q,
    input  cnt_step, cnt_down, grant, busy, done, err
  );

  modport slave (
    input  req, tgt0, tgt1, cnt_q,
    output cnt_step, cnt_down, grant, busy, done, err
  );
endinterface

// File: rtl/cnt_target_arb.sv
// Round-robin owner of a shared up/down counter; steps it to the owner's target, then pulses done.
// Latency: grant 1 edge after req; done in cycle 3*d+1 after grant for d steps (abort after MAX_STEPS).
// Backpressure: req is a level held until done; the loser simply waits, mid-transaction req/tgt changes are ignored.
module cnt_target_arb #(
  parameter int W         = 4,
  parameter bit WRAP      = 1'b1,
  parameter int MAX_STEPS = 16
) (
  input  logic            clk,
  input  logic            rst,
  cnt_target_arb_if.slave bus
);

  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};
  localparam logic [SW-1:0] BUDGET = SW'(MAX_STEPS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMP    = 3'd1,
    STEP   = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state;
  logic          rr;        // requester that wins a tie next time
  logic          own;       // index of the current owner
  logic [W-1:0]  tgt;       // target latched at grant
  logic [SW-1:0] nstep;     // steps issued in this transaction
  logic          dir;       // latched direction, 1 = down
  logic [1:0]    grant_r;
  logic          err_r;

  logic          pick;
  logic [W-1:0]  du;
  logic          dn;
  logic          at_tgt;
  logic          out_of_budget;

  // Winner selection: rr pointer first, otherwise the other requester.
  always_comb begin
    pick = rr;
    if (!bus.req[rr]) begin
      pick = ~rr;
    end
  end

  // Direction: shortest modular path (tie goes up) or plain magnitude compare.
  always_comb begin
    du = tgt - bus.cnt_q;
    dn = 1'b0;
    if (WRAP) begin
      dn = (du > HALF);
    end else begin
      dn = (bus.cnt_q > tgt);
    end
  end

  assign at_tgt        = (bus.cnt_q == tgt);
  assign out_of_budget = (nstep == BUDGET);

  // Transaction FSM with its registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr      <= 1'b0;
      own     <= 1'b0;
      tgt     <= '0;
      nstep   <= '0;
      dir     <= 1'b0;
      grant_r <= 2'b00;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_r <= 1'b0;
          if (|bus.req) begin
            own     <= pick;
            tgt     <= pick ? bus.tgt1 : bus.tgt0;
            grant_r <= pick ? 2'b10 : 2'b01;
            nstep   <= '0;
            state   <= CMP;
          end
        end
        CMP: begin
          if (at_tgt) begin
            err_r <= 1'b0;
            state <= DONE;
          end else if (out_of_budget) begin
            err_r <= 1'b1;
            state <= DONE;
          end else begin
            dir   <= dn;
            state <= STEP;
          end
        end
        STEP: begin
          nstep <= nstep + SW'(1);
          state <= SETTLE;
        end
        SETTLE: begin
          state <= CMP;
        end
        DONE: begin
          rr      <= ~own;
          grant_r <= 2'b00;
          err_r   <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cnt_step = (state == STEP);
  assign bus.cnt_down = dir;
  assign bus.grant    = grant_r;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.err      = err_r;

endmodule

// File: tb/tb_cnt_target_arb.sv
// Directed bench for cnt_target_arb with a behavioural counter on each of two instances.
// Instance a uses WRAP=1, instance b uses WRAP=0; sel routes requests/observation.
// Expected values are hand-computed per vector.
module tb_cnt_target_arb;

  logic clk;
  logic rst;
  logic sel;
  logic [1:0] req_d;
  logic [3:0] tgt0_d;
  logic [3:0] tgt1_d;
  logic       ld;
  logic [3:0] ldv;
  logic [3:0] qa;
  logic [3:0] qb;

  int checks;
  int errors;

  cnt_target_arb_if #(.W(4)) ia ();
  cnt_target_arb_if #(.W(4)) ib ();

  cnt_target_arb #(.W(4), .WRAP(1'b1), .MAX_STEPS(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  cnt_target_arb #(.W(4), .WRAP(1'b0), .MAX_STEPS(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ia.req   = sel ? 2'b00 : req_d;
  assign ib.req   = sel ? req_d : 2'b00;
  assign ia.tgt0  = tgt0_d;
  assign ia.tgt1  = tgt1_d;
  assign ib.tgt0  = tgt0_d;
  assign ib.tgt1  = tgt1_d;
  assign ia.cnt_q = qa;
  assign ib.cnt_q = qb;

  // Counter models: load wins, otherwise step on cnt_step.
  always_ff @(posedge clk) begin
    if (ld) qa <= ldv;
    else if (ia.cnt_step) qa <= ia.cnt_down ? qa - 4'd1 : qa + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (ld) qb <= ldv;
    else if (ib.cnt_step) qb <= ib.cnt_down ? qb - 4'd1 : qb + 4'd1;
  end

  logic [6:0] outs_a;
  logic [6:0] outs_b;
  logic       o_step;
  logic       o_down;
  logic [1:0] o_grant;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [3:0] o_q;

  assign outs_a  = {ia.cnt_step, ia.cnt_down, ia.grant, ia.busy, ia.done, ia.err};
  assign outs_b  = {ib.cnt_step, ib.cnt_down, ib.grant, ib.busy, ib.done, ib.err};
  assign o_step  = sel ? ib.cnt_step : ia.cnt_step;
  assign o_down  = sel ? ib.cnt_down : ia.cnt_down;
  assign o_grant = sel ? ib.grant    : ia.grant;
  assign o_busy  = sel ? ib.busy     : ia.busy;
  assign o_done  = sel ? ib.done     : ia.done;
  assign o_err   = sel ? ib.err      : ia.err;
  assign o_q     = sel ? qb          : qa;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transaction: present r, wait for grant, track steps until done, then present r_after.
  task automatic run_txn(input logic [1:0] r, input logic [1:0] r_after, input logic [1:0] eg,
                         input int esteps, input logic edn, input logic eerr,
                         input logic [3:0] eq, input string tag);
    int   wt;
    int   cyc;
    int   steps;
    logic prev;
    logic seen;
    req_d = r;
    wt = 0;
    do begin
      @(negedge clk);
      wt++;
    end while (o_grant == 2'b00 && wt < 5);
    check({tag, "_lat"}, wt, 1);
    check({tag, "_grant"}, o_grant, eg);
    cyc   = 0;
    steps = 0;
    prev  = 1'b0;
    seen  = 1'b0;
    while (!seen && cyc < 200) begin
      if (o_done) begin
        seen = 1'b1;
      end else begin
        if (o_step) begin
          steps++;
          check({tag, "_dir"}, o_down, edn);
          check({tag, "_gap"}, prev, 0);
        end
        prev = o_step;
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_done_cyc"}, cyc, 3 * esteps + 1);
    check({tag, "_steps"}, steps, esteps);
    check({tag, "_err"}, o_err, eerr);
    check({tag, "_grant_at_done"}, o_grant, eg);
    check({tag, "_q"}, o_q, eq);
    req_d = r_after;
    @(negedge clk);
    check({tag, "_idle"}, {o_grant, o_busy, o_done}, 0);
  endtask

  initial begin
    int   wt;
    logic seen;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sel    = 1'b0;
    req_d  = 2'b00;
    tgt0_d = 4'd0;
    tgt1_d = 4'd0;
    ld     = 1'b1;
    ldv    = 4'd0;

    // Held in reset with random inputs: everything stays 0.
    repeat (6) begin
      @(negedge clk);
      req_d  = 2'($urandom);
      tgt0_d = 4'($urandom);
      tgt1_d = 4'($urandom);
      #1;
      check("rst_outs_a", outs_a, 0);
      check("rst_outs_b", outs_b, 0);
    end
    req_d = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_outs", outs_a, 0);
    end

    // Single up move 3 -> 7.
    ld = 1'b1; ldv = 4'd3;
    @(negedge clk);
    ld = 1'b0; tgt0_d = 4'd7;
    run_txn(2'b01, 2'b00, 2'b01, 4, 1'b0, 1'b0, 4'd7, "up");

    // 14 -> 1 with wrap: 3 up steps.
    ld = 1'b1; ldv = 4'd14;
    @(negedge clk);
    ld = 1'b0; tgt0_d = 4'd1;
    run_txn(2'b01, 2'b00, 2'b01, 3, 1'b0, 1'b0, 4'd1, "wrap1");

    // 14 -> 1 without wrap: 13 down steps.
    sel = 1'b1;
    ld = 1'b1; ldv = 4'd14;
    @(negedge clk);
    ld = 1'b0;
    run_txn(2'b01, 2'b00, 2'b01, 13, 1'b1, 1'b0, 4'd1, "wrap0");
    sel = 1'b0;

    // Zero distance and alternation, both requesting out of reset.
    rst = 1'b1;
    ld = 1'b1; ldv = 4'd5;
    tgt0_d = 4'd5; tgt1_d = 4'd2;
    req_d = 2'b11;
    @(negedge clk);
    @(negedge clk);
    ld = 1'b0;
    rst = 1'b0;
    run_txn(2'b11, 2'b10, 2'b01, 0, 1'b0, 1'b0, 4'd5, "zero");
    run_txn(2'b10, 2'b11, 2'b10, 3, 1'b1, 1'b0, 4'd2, "arb1");
    run_txn(2'b11, 2'b00, 2'b01, 3, 1'b0, 1'b0, 4'd5, "arb2");

    // Stuck counter: budget exhausted, err.
    ld = 1'b1; ldv = 4'd0;
    tgt0_d = 4'd9;
    run_txn(2'b01, 2'b00, 2'b01, 16, 1'b1, 1'b1, 4'd0, "stuck");
    ld = 1'b0;

    // Reset during a step: rr pointer is 1 here, so requester 1 wins first.
    tgt0_d = 4'd7; tgt1_d = 4'd4;
    req_d = 2'b11;
    wt = 0;
    do begin
      @(negedge clk);
      wt++;
    end while (o_grant == 2'b00 && wt < 5);
    check("mid_grant", o_grant, 2'b10);
    seen = 1'b0;
    wt = 0;
    while (!seen && wt < 10) begin
      @(negedge clk);
      wt++;
      if (o_step) seen = 1'b1;
    end
    check("mid_step_seen", seen, 1);
    rst = 1'b1;
    ld = 1'b1; ldv = 4'd0;
    #1;
    check("mid_rst_outs", outs_a, 0);
    @(negedge clk);
    ld = 1'b0;
    rst = 1'b0;
    run_txn(2'b11, 2'b00, 2'b01, 7, 1'b0, 1'b0, 4'd7, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_target_arb.md
Name: cnt_target_arb

Overview:
- Controller and arbiter for one shared W-bit synchronous up/down counter: the counter exposes q and is driven through step/down inputs.
- Two requesters each present a target value. The block grants one requester at a time (round-robin), steps the shared counter one count at a time until its output equals that target, then pulses done.
- Sits between requesting control logic and the counter datapath; it is the only driver of the counter's step/down inputs.

Parameters:
- W, 4, counter width; width of targets and of cnt_q.
- WRAP, 1, 1 = choose the shortest modular direction; 0 = plain magnitude compare (never crosses the wrap point).
- MAX_STEPS, 16, step budget per transaction; exceeding it aborts the transaction with err.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  level request per requester; held until done.
- tgt0  in  W  target for requester 0; sampled at grant.
- tgt1  in  W  target for requester 1; sampled at grant.
- cnt_q  in  W  current shared-counter value; counter updates on the edge ending a step cycle.
- cnt_step  out  1  step enable to the counter.
- cnt_down  out  1  direction to the counter (1 = decrement); valid when cnt_step=1.
- grant  out  2  one-hot owner of the counter; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a transaction ends.
- err  out  1  valid with done: 1 = MAX_STEPS exhausted without reaching the target.

Behaviour:
- Reset (async, any state): state=IDLE, rr pointer=0, latched target=0, step count=0, all outputs 0.
- FSM states: IDLE, CMP, STEP, SETTLE, DONE. All outputs are registered or pure Moore decodes of state.
- IDLE:
  - If req is nonzero, pick the winner: rr pointer first, else the other requester.
  - Latch that requester's target; set grant one-hot; clear step count; go to CMP.
- CMP:
  - cnt_q == target → DONE with err=0.
  - Else if step count == MAX_STEPS → DONE with err=1.
  - Else latch direction, go to STEP.
- Direction:
  - WRAP=0: down = (cnt_q > target).
  - WRAP=1: du = (target − cnt_q) mod 2^W; down = (du > 2^(W−1)). A tie (du == 2^(W−1)) goes up.
- STEP: cnt_step=1 and cnt_down=latched direction for exactly one cycle; step count +1; go to SETTLE.
- SETTLE: cnt_step=0; one cycle to let the counter output settle; go to CMP.
- DONE:
  - done=1 for one cycle; grant still held; err driven.
  - rr pointer ← index of the non-granted requester.
  - Next state IDLE, where grant clears.
- Timing:
  - Grant first high in cycle 0 (CMP).
  - With d required steps and no abort, done is high in cycle 3·d+1.
  - IDLE→grant latency is 1 edge after req is sampled.
- Back-to-back: at least one IDLE cycle between transactions.
- Request rules:
  - Dropping req mid-transaction is ignored: the latched target completes.
  - Target changes after grant are ignored.
- Simultaneous requests in IDLE are resolved by the rr pointer; the loser keeps waiting.
- cnt_step is never high in two consecutive cycles, and never high outside STEP.
- Width rules: direction math is W-bit modular; step count is wide enough to hold MAX_STEPS.

Test Plan:
- Reset, then idle: hold rst=1 with random inputs → all outputs 0. Release rst with req=0 for 10 cycles → outputs stay 0.
- Single up move: counter model at 3, req=01, tgt0=7 → grant=01, four cnt_step pulses with cnt_down=0, q reaches 7, done=1 and err=0 in cycle 13, grant=00 next cycle.
- Wrap choice: q=14, tgt0=1.
  - WRAP=1 → 3 up steps (15, 0, 1), done in cycle 10.
  - WRAP=0 → 13 down steps, done in cycle 40.
- Zero distance plus arbitration:
  - req=11 at reset with q=5, tgt0=5, tgt1=2 → grant=01 first, done in cycle 1 with no steps.
  - Then grant=10 → 3 down steps to 2.
  - Then req=11 again → grant=01 (alternation).
- Stuck counter: cnt_q held at 0, tgt0=9 → exactly MAX_STEPS=16 step pulses, then done=1 with err=1; grant clears after.
- Reset mid-move: assert rst during a STEP cycle → cnt_step, grant and busy drop immediately. After release, a new request is granted to requester 0.
